// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the load/store unit.
// One transaction in flight; data side has priority, bounded by a fetch-starvation guard.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  streak;
  logic [2:0]  lat_cnt;
  logic        owner_fetch;
  logic        arb_active;
  logic        fetch_win;
  logic        unused_addr_bits;

  // Byte offsets are dropped: the RAM is word addressed.
  always_comb unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = (if_gnt || d_gnt) ? ISSUE : IDLE;
      ISSUE:      state_nxt = WAIT;
      WAIT:       if (lat_cnt == 3'd1) state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  // Grants are gated by reset so a request presented during reset is not lost.
  always_comb begin
    arb_active = !reset && (state == IDLE || state == RESP);
    fetch_win  = if_req && (!d_req || streak == 4'(STARVE_LIMIT));
    if_gnt     = arb_active && fetch_win;
    d_gnt      = arb_active && d_req && !fetch_win;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      if_rvalid   <= 1'b0;
      if_rdata    <= '0;
      d_rvalid    <= 1'b0;
      d_rdata     <= '0;
      streak      <= '0;
      lat_cnt     <= '0;
      owner_fetch <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;

      if (if_gnt) begin
        mem_en      <= 1'b1;
        mem_we      <= 1'b0;
        mem_addr    <= {if_addr[31:2], 2'b00};
        mem_wdata   <= '0;
        mem_wmask   <= '0;
        owner_fetch <= 1'b1;
        streak      <= '0;
      end else if (d_gnt) begin
        mem_en      <= 1'b1;
        mem_we      <= d_we;
        mem_addr    <= {d_addr[31:2], 2'b00};
        mem_wdata   <= d_wdata;
        mem_wmask   <= d_wmask;
        owner_fetch <= 1'b0;
        if (!if_req)
          streak <= '0;
        else if (streak != 4'(STARVE_LIMIT))
          streak <= streak + 4'd1;
      end

      // mem_we still holds the owner's access type while waiting for the RAM.
      if (state == ISSUE) begin
        lat_cnt <= 3'(MEM_LATENCY);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          if (owner_fetch) begin
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end else begin
            d_rdata  <= mem_we ? '0 : mem_rdata;
            d_rvalid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance 0 runs MEM_LATENCY=1, instance 1 runs MEM_LATENCY=3.
// Stimulus pushes expected grants, RAM issues, responses and reset snapshots; a negedge monitor pops them.
module tb_mem_port_arbiter;

  typedef struct {
    int unsigned dut;
    int unsigned cyc;
    logic        fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        d_req     [2];
  logic [31:0] d_addr    [2];
  logic        d_we      [2];
  logic [31:0] d_wdata   [2];
  logic [3:0]  d_wmask   [2];
  logic        d_gnt     [2];
  logic        d_rvalid  [2];
  logic [31:0] d_rdata   [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wmask [2];
  logic [31:0] mem_rdata [2];

  int unsigned cyc = 0;
  int unsigned timeouts = 0;
  bit          mon_on = 1'b0;
  bit          done = 1'b0;
  ev_t         gq[$];
  ev_t         iq[$];
  ev_t         rq[$];
  ev_t         sq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] ram  [256];
    logic [31:0] pipe [3];

    mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_addr(d_addr[g]), .d_we(d_we[g]),
      .d_wdata(d_wdata[g]), .d_wmask(d_wmask[g]), .d_gnt(d_gnt[g]),
      .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_wmask(mem_wmask[g]), .mem_rdata(mem_rdata[g])
    );

    // RAM model: contents reload on reset; read data appears LAT cycles after mem_en.
    always @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 256; i++) ram[i] <= '0;
        ram[1]  <= 32'hCAFE_BABE;
        ram[4]  <= 32'hD0D0_D0D0;
        ram[8]  <= 32'h1122_3344;
        ram[16] <= 32'hF0F0_F0F0;
        ram[32] <= 32'h1234_5678;
        for (int i = 0; i < 3; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= 32'hDEAD_BEEF;
        if (mem_en[g]) begin
          if (mem_we[g]) begin
            for (int b = 0; b < 4; b++)
              if (mem_wmask[g][b]) ram[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
          end else begin
            pipe[0] <= ram[mem_addr[g][9:2]];
          end
        end
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
      end
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic step(int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_g(int unsigned d, int unsigned c, logic f);
    gq.push_back('{d, c, f, 1'b0, 32'h0, 32'h0, 4'h0});
  endtask

  task automatic exp_i(int unsigned d, int unsigned c, logic we, logic [31:0] a,
                       logic [31:0] wd, logic [3:0] m);
    iq.push_back('{d, c, 1'b0, we, a, wd, m});
  endtask

  task automatic exp_r(int unsigned d, int unsigned c, logic f, logic [31:0] rd);
    rq.push_back('{d, c, f, 1'b0, 32'h0, rd, 4'h0});
  endtask

  task automatic snap(int unsigned d);
    sq.push_back('{d, cyc, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0});
  endtask

  task automatic start_d(int unsigned d, logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] m);
    d_req[d]   = 1'b1;
    d_addr[d]  = a;
    d_we[d]    = we;
    d_wdata[d] = wd;
    d_wmask[d] = m;
  endtask

  task automatic start_f(int unsigned d, logic [31:0] a);
    if_req[d]  = 1'b1;
    if_addr[d] = a;
  endtask

  task automatic wait_drop(int unsigned d, bit fetch);
    int unsigned n = 0;
    #1;
    while (!(fetch ? if_gnt[d] : d_gnt[d]) && n < 20) begin
      step(1);
      n++;
    end
    if (n == 20) timeouts++;
    step(1);
    if (fetch) if_req[d] = 1'b0;
    else       d_req[d]  = 1'b0;
  endtask

  initial begin
    int unsigned t0;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 1'b0; if_addr[d] = '0;
      d_req[d] = 1'b0; d_addr[d] = '0; d_we[d] = 1'b0; d_wdata[d] = '0; d_wmask[d] = '0;
    end
    reset = 1'b1;
    step(2);
    reset  = 1'b0;
    mon_on = 1'b1;
    snap(0);
    snap(1);
    step(1);

    // Load from a misaligned address
    t0 = cyc;
    exp_g(0, t0, 1'b0);
    exp_i(0, t0 + 1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
    exp_r(0, t0 + 3, 1'b0, 32'hCAFE_BABE);
    start_d(0, 1'b0, 32'h0000_1006, 32'h0, 4'h0);
    wait_drop(0, 1'b0);
    step(4);

    // Masked store, then read back the merged word
    t0 = cyc;
    exp_g(0, t0, 1'b0);
    exp_i(0, t0 + 1, 1'b1, 32'h0000_0020, 32'h00AB_0000, 4'b0100);
    exp_r(0, t0 + 3, 1'b0, 32'h0);
    start_d(0, 1'b1, 32'h0000_0020, 32'h00AB_0000, 4'b0100);
    wait_drop(0, 1'b0);
    step(4);
    t0 = cyc;
    exp_g(0, t0, 1'b0);
    exp_i(0, t0 + 1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    exp_r(0, t0 + 3, 1'b0, 32'h11AB_3344);
    start_d(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    wait_drop(0, 1'b0);
    step(4);

    // Both sides requesting continuously: D D D D F D D D D F, 3 cycles apart
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      logic f;
      f = (k == 4 || k == 9);
      exp_g(0, t0 + 3*k, f);
      exp_i(0, t0 + 3*k + 1, 1'b0, f ? 32'h0000_0040 : 32'h0000_0010, 32'h0, 4'h0);
      exp_r(0, t0 + 3*k + 3, f, f ? 32'hF0F0_F0F0 : 32'hD0D0_D0D0);
    end
    start_f(0, 32'h0000_0041);
    start_d(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    step(28);
    if_req[0] = 1'b0;
    d_req[0]  = 1'b0;
    step(4);

    // Fetch in flight; a one-cycle d_req during WAIT must be ignored
    t0 = cyc;
    exp_g(0, t0, 1'b1);
    exp_i(0, t0 + 1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    exp_r(0, t0 + 3, 1'b1, 32'hF0F0_F0F0);
    start_f(0, 32'h0000_0040);
    wait_drop(0, 1'b1);
    step(1);
    start_d(0, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
    step(1);
    d_req[0] = 1'b0;
    step(4);

    // Reset in the middle of a load: no response, clean restart
    t0 = cyc;
    exp_g(0, t0, 1'b0);
    exp_i(0, t0 + 1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    start_d(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    wait_drop(0, 1'b0);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    snap(0);
    step(1);
    t0 = cyc;
    exp_g(0, t0, 1'b1);
    exp_i(0, t0 + 1, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
    exp_r(0, t0 + 3, 1'b1, 32'h1234_5678);
    start_f(0, 32'h0000_0080);
    wait_drop(0, 1'b1);
    step(4);

    // MEM_LATENCY=3: fetch response at +5, a d_req raised at +2 is granted at +5
    t0 = cyc;
    exp_g(1, t0, 1'b1);
    exp_i(1, t0 + 1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    exp_r(1, t0 + 5, 1'b1, 32'hF0F0_F0F0);
    exp_g(1, t0 + 5, 1'b0);
    exp_i(1, t0 + 6, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
    exp_r(1, t0 + 10, 1'b0, 32'hCAFE_BABE);
    start_f(1, 32'h0000_0040);
    wait_drop(1, 1'b1);
    step(1);
    start_d(1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
    wait_drop(1, 1'b0);
    step(6);

    done = 1'b1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1);
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned timeouts_seen = 0;

  always @(negedge clk) begin
    ev_t          e;
    logic [137:0] sv;
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        if (if_gnt[d] || d_gnt[d]) begin
          checks++;
          if (gq.size() == 0) begin
            errors++;
            $display("FAIL grant: dut%0d cyc %0d if_gnt=%0b d_gnt=%0b, want no grant", d, cyc, if_gnt[d], d_gnt[d]);
          end else begin
            e = gq.pop_front();
            if (e.dut != d || e.cyc != cyc || e.fetch != if_gnt[d] || (if_gnt[d] && d_gnt[d])) begin
              errors++;
              $display("FAIL grant: dut%0d cyc %0d if_gnt=%0b d_gnt=%0b, want dut%0d cyc %0d fetch=%0b",
                       d, cyc, if_gnt[d], d_gnt[d], e.dut, e.cyc, e.fetch);
            end
          end
        end
        if (mem_en[d]) begin
          checks++;
          if (iq.size() == 0) begin
            errors++;
            $display("FAIL issue: dut%0d cyc %0d mem_en=1 addr=%h, want no access", d, cyc, mem_addr[d]);
          end else begin
            e = iq.pop_front();
            if (e.dut != d || e.cyc != cyc || e.we != mem_we[d] || e.addr != mem_addr[d] ||
                e.data != mem_wdata[d] || e.mask != mem_wmask[d]) begin
              errors++;
              $display("FAIL issue: dut%0d cyc %0d we=%0b addr=%h wdata=%h wmask=%b, want dut%0d cyc %0d we=%0b addr=%h wdata=%h wmask=%b",
                       d, cyc, mem_we[d], mem_addr[d], mem_wdata[d], mem_wmask[d],
                       e.dut, e.cyc, e.we, e.addr, e.data, e.mask);
            end
          end
        end
        if (if_rvalid[d] || d_rvalid[d]) begin
          checks++;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL response: dut%0d cyc %0d if_rvalid=%0b d_rvalid=%0b, want no response",
                     d, cyc, if_rvalid[d], d_rvalid[d]);
          end else begin
            e = rq.pop_front();
            if (e.dut != d || e.cyc != cyc || e.fetch != if_rvalid[d] || (if_rvalid[d] && d_rvalid[d]) ||
                e.data != (if_rvalid[d] ? if_rdata[d] : d_rdata[d])) begin
              errors++;
              $display("FAIL response: dut%0d cyc %0d if_rvalid=%0b d_rvalid=%0b if_rdata=%h d_rdata=%h, want dut%0d cyc %0d fetch=%0b data=%h",
                       d, cyc, if_rvalid[d], d_rvalid[d], if_rdata[d], d_rdata[d],
                       e.dut, e.cyc, e.fetch, e.data);
            end
          end
        end
        if (sq.size() != 0 && sq[0].dut == d && sq[0].cyc == cyc) begin
          e = sq.pop_front();
          checks++;
          sv = {if_gnt[d], d_gnt[d], mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], mem_wmask[d],
                if_rvalid[d], d_rvalid[d], if_rdata[d], d_rdata[d]};
          if (sv != '0) begin
            errors++;
            $display("FAIL reset_state: dut%0d cyc %0d outputs=%h, want all zero", d, cyc, sv);
          end
        end
      end
      if (timeouts != timeouts_seen) begin
        checks++;
        errors++;
        $display("FAIL handshake: %0d grant waits expired, want 0", timeouts);
        timeouts_seen = timeouts;
      end
    end
    if (done) begin
      checks++;
      if (gq.size() != 0) begin
        errors++;
        $display("FAIL grant_drain: %0d grants never seen, want 0", gq.size());
      end
      checks++;
      if (iq.size() != 0) begin
        errors++;
        $display("FAIL issue_drain: %0d issues never seen, want 0", iq.size());
      end
      checks++;
      if (rq.size() + sq.size() != 0) begin
        errors++;
        $display("FAIL response_drain: %0d responses/snapshots never seen, want 0", rq.size() + sq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous data/instruction RAM between the instruction-fetch unit and the load/store memory controller. Only one transaction is outstanding at a time. The data side has priority, and a starvation guard bounds how long fetch can be locked out. The block sits between the core's fetch stage, the lane-positioning memory controller, and the RAM macro.

Parameters:
- MEM_LATENCY, 1: cycles from mem_en high to mem_rdata valid; legal range 1..4.
- STARVE_LIMIT, 4: maximum consecutive data grants while fetch is waiting; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request.
- d_addr  in  32  data byte address.
- d_we  in  1  1 = store, 0 = load.
- d_wdata  in  32  store data, already lane-positioned.
- d_wmask  in  4  byte-lane write enables.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  one-cycle pulse; load data valid, or store acknowledged.
- d_rdata  out  32  raw load word; 0 for stores.
- mem_en  out  1  RAM access strobe (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_addr  out  32  RAM word address, {addr[31:2], 2'b00} (registered).
- mem_wdata  out  32  RAM write data (registered).
- mem_wmask  out  4  RAM byte mask (registered).
- mem_rdata  in  32  RAM read data, valid MEM_LATENCY cycles after mem_en.

Behaviour:
- Reset: every registered output is 0; state = IDLE; streak counter = 0; latency counter = 0.
- Reset mid-transaction: the transaction is abandoned, no rvalid is emitted, and mem_en is 0 from the next cycle.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select a winner and assert its gnt in the same cycle (combinational).
  - Capture the winner's address, we, wdata and wmask; capture the owner ID; go to ISSUE.
  - If no req is high, no gnt is asserted.
- ISSUE (1 cycle):
  - mem_en = 1, with mem_we/addr/wdata/wmask from the captured values.
  - Fetch captures always have mem_we = 0 and mem_wmask = 0.
  - Load latency counter with MEM_LATENCY; go to WAIT.
- WAIT:
  - mem_en = 0; decrement the counter.
  - In the cycle the counter reaches 1, register mem_rdata (loads/fetches) or 0 (stores) into the owner's rdata; go to RESP.
- RESP (1 cycle):
  - Owner's rvalid = 1 and rdata holds the captured word; the other rvalid stays 0.
  - Behaves as IDLE for arbitration, so a new gnt may coincide with rvalid.
- Latency and throughput: req/gnt at cycle T gives mem_en at T+1 and rvalid at T+2+MEM_LATENCY. Back-to-back throughput is one transaction per MEM_LATENCY+2 cycles.
- Arbitration:
  - Data wins unless if_req is high and streak == STARVE_LIMIT, in which case fetch wins.
  - Streak increments on a data grant made while if_req is high, saturating at STARVE_LIMIT.
  - Streak clears on any fetch grant, or on a data grant made while if_req is low.
- Requester rules:
  - A requester holds req and payload stable until gnt.
  - Dropping req before gnt is legal and starts no transaction.
  - Inputs are don't-care after gnt.
  - A req asserted while ISSUE/WAIT is active is ignored until IDLE/RESP.
- Addressing and data:
  - addr[1:0] is discarded; misaligned fetch addresses are issued word-aligned with no error.
  - d_wdata and d_wmask pass through unmodified; byte extraction and sign extension are done downstream.
- Output hygiene: gnt is never asserted in ISSUE or WAIT; if_gnt and d_gnt are never high together; rdata outputs hold their last value outside rvalid.

Test Plan:
- MEM_LATENCY = 1; d_req load at cycle 0, d_addr = 0x1006, mem_rdata = 0xCAFEBABE -> d_gnt at cycle 0; mem_en = 1 with mem_addr = 0x1004 at cycle 1; d_rvalid = 1 with d_rdata = 0xCAFEBABE at cycle 3.
- Store d_addr = 0x20, d_wdata = 0x00AB0000, d_wmask = 4'b0100 -> cycle 1 shows mem_we = 1, mem_wdata = 0x00AB0000, mem_wmask = 4'b0100; d_rvalid at cycle 3 with d_rdata = 0; if_rvalid stays 0.
- if_req and d_req held high continuously, STARVE_LIMIT = 4 -> grant order D, D, D, D, F, D, D, D, D, F; grants spaced exactly 3 cycles apart.
- MEM_LATENCY = 3; fetch at 0x40 -> mem_en at cycle 1, if_rvalid at cycle 5; a d_req raised at cycle 2 is granted at cycle 5.
- Reset pulsed at cycle 2 of an in-flight load -> no d_rvalid; all outputs 0 at cycle 3; a new request at cycle 4 is granted normally.
- d_req pulsed for one cycle during WAIT, then dropped -> no d_gnt and no memory access ever issued for it.
